// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and fetch-request stage of the MIPS core. It picks the next
// fetch address from the sequential, branch, jump and jump-register sources
// and drives a valid/ready request to instruction memory. The branch offset
// comes from the upstream shift-left-by-2 block, so it is already a byte
// offset. It only has to be added to the PC+4 base.
//
// Ports
//   i_clk            clock; all state changes on the rising edge
//   i_rst            synchronous reset, active-high; overrides every input
//   i_stall          hold the PC because of a pipeline hazard
//   i_branch_taken   a branch resolved taken this cycle
//   i_branch_base    PC+4 of the branch/jump instruction
//   i_branch_offset  sign-extended immediate, already shifted left by 2
//   i_jump           J/JAL this cycle
//   i_jump_index     26-bit instr_index field
//   i_jump_reg       JR/JALR this cycle
//   i_jump_reg_addr  register-sourced jump target
//   i_imem_ready     instruction memory accepts the request
//   o_pc             current fetch address (registered)
//   o_pc_plus4       o_pc + 4 (combinational)
//   o_imem_req       fetch request valid (registered)
//   o_redirect       one-cycle pulse: the PC was redirected on the last edge
//   o_misaligned     sticky error: the jump-register target was misaligned
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_base,
    input  logic [WIDTH-1:0] i_branch_offset,
    input  logic             i_jump,
    input  logic [25:0]      i_jump_index,
    input  logic             i_jump_reg,
    input  logic [WIDTH-1:0] i_jump_reg_addr,
    input  logic             i_imem_ready,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus4,
    output logic             o_imem_req,
    output logic             o_redirect,
    output logic             o_misaligned
);

    // Byte distance between sequential instruction words.
    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] pc_r;
    logic             imem_req_r;
    logic             redirect_r;
    logic             misaligned_r;

    logic [WIDTH-1:0] jump_target_s;
    logic [WIDTH-1:0] branch_target_s;
    logic             jr_misaligned_s;
    logic             transfer_s;

    // Candidate redirect targets and the handshake, computed from the inputs.
    always_comb begin
        // J-type target keeps the top nibble of the delay-slot PC.
        jump_target_s   = {i_branch_base[WIDTH-1:WIDTH-4], i_jump_index, 2'b00};
        // Modulo-2^WIDTH add. A wrapping target is legal and is not flagged.
        branch_target_s = i_branch_base + i_branch_offset;
        jr_misaligned_s = (i_jump_reg_addr[1:0] != 2'b00);
        transfer_s      = imem_req_r & i_imem_ready;
    end

    // Fetch FSM: state, PC and every registered output are updated together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_VECTOR;
            imem_req_r   <= 1'b0;
            redirect_r   <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    // The idle first cycle lets the memory side settle.
                    // Redirects that arrive in this cycle are dropped.
                    state_r    <= ST_RUN;
                    imem_req_r <= 1'b1;
                    redirect_r <= 1'b0;
                end

                ST_RUN: begin
                    if (i_jump_reg) begin
                        if (jr_misaligned_s) begin
                            // Fetching from a bad target is never allowed.
                            // The PC freezes at its last good value.
                            state_r      <= ST_ERROR;
                            imem_req_r   <= 1'b0;
                            redirect_r   <= 1'b0;
                            misaligned_r <= 1'b1;
                        end else begin
                            pc_r       <= i_jump_reg_addr;
                            redirect_r <= 1'b1;
                        end
                    end else if (i_jump) begin
                        pc_r       <= jump_target_s;
                        redirect_r <= 1'b1;
                    end else if (i_branch_taken) begin
                        pc_r       <= branch_target_s;
                        redirect_r <= 1'b1;
                    end else if (i_stall) begin
                        // The request stays up, so an accepted transfer is
                        // simply repeated at the same address.
                        redirect_r <= 1'b0;
                    end else if (transfer_s) begin
                        pc_r       <= pc_r + PC_STEP;
                        redirect_r <= 1'b0;
                    end else begin
                        // Waiting for memory: the address must stay stable.
                        redirect_r <= 1'b0;
                    end
                end

                ST_ERROR: begin
                    // Only reset leaves this state.
                    imem_req_r   <= 1'b0;
                    redirect_r   <= 1'b0;
                    misaligned_r <= 1'b1;
                end

                default: begin
                    // An illegal encoding restarts the boot sequence.
                    // The PC is kept as it is.
                    state_r    <= ST_BOOT;
                    imem_req_r <= 1'b0;
                    redirect_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc         = pc_r;
    assign o_pc_plus4   = pc_r + PC_STEP;
    assign o_imem_req   = imem_req_r;
    assign o_redirect   = redirect_r;
    assign o_misaligned = misaligned_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// The bench drives a table of stimulus records. Each record carries the
// outputs it expects after the next clock edge. That expectation is pushed
// onto a scoreboard queue when the record is driven. It is popped and
// compared once the edge has happened. A hand-written sequence follows the
// table: it runs sequential fetch with random ready/stall against a small
// PC model.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_base;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_reg_addr;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        redirect;
    logic        misaligned;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] base;
        logic [31:0] off;
        logic        jump;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jraddr;
        logic        ready;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_red;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        red;
        logic        mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   compared;
    int   mismatched;

    pc_fetch_unit #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_base   (branch_base),
        .i_branch_offset (branch_offset),
        .i_jump          (jump),
        .i_jump_index    (jump_index),
        .i_jump_reg      (jump_reg),
        .i_jump_reg_addr (jump_reg_addr),
        .i_imem_ready    (imem_ready),
        .o_pc            (pc),
        .o_pc_plus4      (pc_plus4),
        .o_imem_req      (imem_req),
        .o_redirect      (redirect),
        .o_misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic st, input logic br,
                                input logic [31:0] base, input logic [31:0] off,
                                input logic j, input logic [25:0] idx,
                                input logic jr, input logic [31:0] jra,
                                input logic rdy, input logic [31:0] epc,
                                input logic ereq, input logic ered,
                                input logic emis);
        vec_t v;
        v.rst = r;   v.stall = st; v.br = br;   v.base = base; v.off = off;
        v.jump = j;  v.idx = idx;  v.jr = jr;   v.jraddr = jra; v.ready = rdy;
        v.e_pc = epc; v.e_req = ereq; v.e_red = ered; v.e_mis = emis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;          stall = v.stall;      branch_taken = v.br;
        branch_base = v.base; branch_offset = v.off; jump = v.jump;
        jump_index = v.idx;   jump_reg = v.jr;      jump_reg_addr = v.jraddr;
        imem_ready = v.ready;
    endtask

    // Drive one cycle and queue its expectation. Then pop it after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        drive(v);
        e.pc = v.e_pc; e.req = v.e_req; e.red = v.e_red; e.mis = v.e_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            check({tag, ".pc"},       pc,                 got.pc);
            check({tag, ".pc_plus4"}, pc_plus4,           got.pc + 32'd4);
            check({tag, ".req"},      {31'd0, imem_req},  {31'd0, got.req});
            check({tag, ".redirect"}, {31'd0, redirect},  {31'd0, got.red});
            check({tag, ".mis"},      {31'd0, misaligned},{31'd0, got.mis});
        end
    endtask

    initial begin
        logic [31:0] model_pc;
        vec_t        v;
        compared   = 0;
        mismatched = 0;
        drive(mk(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0,
                 1'b0, 32'd0, 1'b0, 1'b0, 1'b0));

        //          rst  stl  br   base          off           j    idx           jr   jraddr        rdy  pc            req  red  mis
        vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0000,1'b0,1'b0,1'b0)); // reset
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h100,     32'h0,       1'b1,26'h3,      1'b0,32'h0,       1'b1,32'h0000_0000,1'b1,1'b0,1'b0)); // boot: redirects ignored
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0004,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0008,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_000C,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0010,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b0,32'h0000_0010,1'b1,1'b0,1'b0)); // not ready x3
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b0,32'h0000_0010,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b0,32'h0000_0010,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0014,1'b1,1'b0,1'b0)); // ready
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h18,      32'h28,      1'b0,26'h0,      1'b0,32'h0,       1'b0,32'h0000_0040,1'b1,1'b1,1'b0)); // branch to 0x40
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h44,      32'hFFFF_FFF0,1'b0,26'h0,     1'b0,32'h0,       1'b1,32'h0000_0034,1'b1,1'b1,1'b0)); // back-to-back
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0038,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0038,1'b1,1'b0,1'b0)); // stall + transfer
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h8000_0008,32'h0,      1'b1,26'h0000100,1'b0,32'h0,       1'b1,32'h8000_0400,1'b1,1'b1,1'b0)); // jump beats stall
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'hFFFF_FFF0,32'h20,     1'b0,26'h0,      1'b0,32'h0,       1'b0,32'h0000_0010,1'b1,1'b1,1'b0)); // branch wraps
        vecs.push_back(mk(1'b0,1'b1,1'b1,32'h4,       32'h4,       1'b1,26'h5,      1'b1,32'h0000_0200,1'b0,32'h0000_0200,1'b1,1'b1,1'b0)); // jr wins
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b0,32'h0000_0200,1'b1,1'b0,1'b0)); // stalled, not ready
        vecs.push_back(mk(1'b1,1'b1,1'b1,32'h40,      32'h40,      1'b1,26'h7,      1'b0,32'h0,       1'b0,32'h0000_0000,1'b0,1'b0,1'b0)); // reset mid-request
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0000,1'b1,1'b0,1'b0)); // boot
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0004,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b1,26'h9,      1'b1,32'h0000_0102,1'b1,32'h0000_0004,1'b0,1'b0,1'b1)); // misaligned jr
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h100,     32'h100,     1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0004,1'b0,1'b0,1'b1)); // ignored
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b1,26'h40,     1'b1,32'h0000_0100,1'b1,32'h0000_0004,1'b0,1'b0,1'b1)); // ignored
        vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0000,1'b0,1'b0,1'b0)); // reset clears error
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0000,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b1,32'hFFFF_FFFC,1'b1,32'hFFFF_FFFC,1'b1,1'b1,1'b0)); // jr to top
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,26'h0,      1'b0,32'h0,       1'b1,32'h0000_0000,1'b1,1'b0,1'b0)); // PC wraps

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Hand-written sequence: random ready/stall run against a PC model.
        step(mk(1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,26'h0,1'b0,32'h0,1'b0,
                32'h0,1'b0,1'b0,1'b0), "seq_rst");
        step(mk(1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,26'h0,1'b0,32'h0,1'b1,
                32'h0,1'b1,1'b0,1'b0), "seq_boot");
        model_pc = 32'h0;
        for (int k = 0; k < 30; k++) begin
            v = mk(1'b0, 1'($urandom_range(0, 3) == 0), 1'b0, 32'h0, 32'h0,
                   1'b0, 26'h0, 1'b0, 32'h0, 1'($urandom_range(0, 1)),
                   32'h0, 1'b1, 1'b0, 1'b0);
            if (!v.stall && v.ready) model_pc = model_pc + 32'd4;
            v.e_pc = model_pc;
            step(v, $sformatf("seq%0d", k));
        end

        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and fetch-request stage for the MIPS core.
- Sits directly downstream of the branch-offset left-shift-by-2 block and consumes its output (the word-aligned branch offset). Forms the branch target from that offset.
- Selects the next PC from sequential, branch, jump and jump-register sources, and drives a valid/ready fetch request to instruction memory.

Parameters:
WIDTH, 32, address/data width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_stall  input  1  hold the PC (pipeline hazard)
i_branch_taken  input  1  branch resolved taken this cycle
i_branch_base  input  WIDTH  PC+4 of the branch/jump instruction
i_branch_offset  input  WIDTH  sign-extended immediate already shifted left by 2
i_jump  input  1  J/JAL this cycle
i_jump_index  input  26  instr_index field
i_jump_reg  input  1  JR/JALR this cycle
i_jump_reg_addr  input  WIDTH  register-sourced target
i_imem_ready  input  1  instruction memory accepts request
o_pc  output  WIDTH  current fetch address
o_pc_plus4  output  WIDTH  o_pc + 4, combinational
o_imem_req  output  1  fetch request valid
o_redirect  output  1  registered pulse: PC was redirected last cycle
o_misaligned  output  1  sticky error: misaligned jump-register target

Behaviour:
- Reset (i_rst high at edge): o_pc=RESET_VECTOR, o_imem_req=0, o_redirect=0, o_misaligned=0, state=BOOT. Reset overrides all other inputs, including mid-transfer.
- States:
  - BOOT: one cycle, o_imem_req=0, then go to RUN.
  - RUN: o_imem_req=1.
  - ERROR: o_imem_req=0, o_pc frozen, o_misaligned=1. Exit only via reset.
- Transfer = o_imem_req && i_imem_ready.
- Next-PC priority in RUN, highest first:
  1. i_jump_reg: target = i_jump_reg_addr. If target[1:0] != 0, go to ERROR, o_pc unchanged, o_redirect=0.
  2. i_jump: target = {i_branch_base[31:28], i_jump_index, 2'b00}.
  3. i_branch_taken: target = i_branch_base + i_branch_offset, modulo 2^WIDTH. Wrap-around is allowed and not flagged.
  4. i_stall: o_pc held.
  5. Transfer: o_pc <= o_pc + 4. Wraps from 32'hFFFF_FFFC to 0.
  6. Otherwise o_pc held; request stays asserted with a stable address.
- Redirect:
  - Any accepted redirect (priorities 1–3 with a valid target) loads o_pc next edge, regardless of i_stall or i_imem_ready.
  - o_redirect=1 for exactly that following cycle. A pending unaccepted request is abandoned.
  - Redirects on consecutive cycles each take effect; o_redirect stays high for both.
- Stall does not drop o_imem_req. The PC is held even if a transfer occurs during stall, so the same address is re-requested.
- Redirect/jump inputs arriving in BOOT or ERROR are ignored.
- Latency: redirect input to new o_pc = 1 cycle. Transfer to next sequential o_pc = 1 cycle.
- o_pc[1:0] is always 2'b00 when RESET_VECTOR is aligned.

Test Plan:
- Reset, then i_imem_ready=1 constant, no control inputs -> o_imem_req=0 for 1 cycle; then o_pc=0,4,8,12 on successive cycles.
- At o_pc=32'h40: i_branch_taken=1, i_branch_base=32'h44, i_branch_offset=32'hFFFF_FFF0 -> next o_pc=32'h34, o_redirect=1 for one cycle.
- i_imem_ready=0 for 3 cycles at o_pc=32'h10 -> o_pc stays 32'h10, o_imem_req=1; on ready, o_pc=32'h14.
- i_jump=1, i_jump_index=26'h0000100, i_branch_base=32'h8000_0008, with i_stall=1 simultaneously -> o_pc=32'h8000_0400; jump wins over stall.
- i_jump_reg=1, i_jump_reg_addr=32'h0000_0102 -> o_misaligned=1, o_imem_req=0, o_pc frozen; later branches ignored; i_rst clears everything to RESET_VECTOR.
- Reset asserted in the middle of a stalled, not-ready request at o_pc=32'h200 -> next cycle o_pc=RESET_VECTOR, o_imem_req=0, o_redirect=0.
